// File: rtl/vscale_dmem_bridge_pkg.sv
// Shared constants for the dmem bridge: FSM state encoding, access-size decode
// and strobe width. Imported by the bridge top and its strobe generator.
package vscale_dmem_bridge_pkg;

  localparam int XPR_LEN        = 32;
  localparam int MEM_TYPE_WIDTH = 3;
  localparam int STRB_W         = XPR_LEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_t;

  function automatic logic [1:0] mem_size(input logic [MEM_TYPE_WIDTH-1:0] mem_type);
    return mem_type[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      SZ_ILL:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vscale_dmem_strb_gen.sv
// Combinational byte-strobe and misalignment decode for one dmem access.
module vscale_dmem_strb_gen
  import vscale_dmem_bridge_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_addr_lo,
  input  logic              i_wen,
  output logic [STRB_W-1:0] o_wstrb,
  output logic              o_misaligned
);

  always_comb begin
    o_misaligned = is_misaligned(i_size, i_addr_lo);
    o_wstrb      = '0;
    // Loads never drive strobes, regardless of size.
    if (i_wen) begin
      case (i_size)
        SZ_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
        SZ_HALF: o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
        SZ_WORD: o_wstrb = 4'b1111;
        default: o_wstrb = '0;
      endcase
    end
  end

endmodule

// File: rtl/vscale_dmem_bridge.sv
// Converts the core's pipelined dmem port into a single-outstanding
// valid/ready request plus response bus, with error and timeout reporting.
module vscale_dmem_bridge
  import vscale_dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [XPR_LEN-1:0]        dmem_addr,
  input  logic [XPR_LEN-1:0]        dmem_wdata_delayed,
  output logic                      dmem_wait,
  output logic [XPR_LEN-1:0]        dmem_rdata,
  output logic                      dmem_badmem_e,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic [XPR_LEN-1:0]        bus_req_addr,
  output logic                      bus_req_wen,
  output logic [STRB_W-1:0]         bus_req_wstrb,
  output logic [XPR_LEN-1:0]        bus_req_wdata,
  input  logic                      bus_resp_valid,
  input  logic [XPR_LEN-1:0]        bus_resp_rdata,
  input  logic                      bus_resp_err
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [XPR_LEN-1:2]   r_addr;
  logic                 r_wen;
  logic [STRB_W-1:0]    r_wstrb;
  logic [XPR_LEN-1:0]   r_wdata;
  logic                 r_req_valid;
  logic                 r_first;
  logic [CNT_W-1:0]     r_cnt;

  logic [STRB_W-1:0]    w_wstrb;
  logic                 w_misaligned;
  logic                 w_timeout;
  logic                 w_complete;
  logic                 w_accept;

  vscale_dmem_strb_gen u_strb_gen (
    .i_size       (mem_size(dmem_size)),
    .i_addr_lo    (dmem_addr[1:0]),
    .i_wen        (dmem_wen),
    .o_wstrb      (w_wstrb),
    .o_misaligned (w_misaligned)
  );

  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == ST_RESP) &&
                      !bus_resp_valid && (r_cnt == LP_CNT_LAST);
  assign w_complete = (r_state == ST_ERR) ||
                      ((r_state == ST_RESP) && (bus_resp_valid || w_timeout));
  // The completion cycle releases the core, so a request seen there is the next address phase.
  assign w_accept   = dmem_en && ((r_state == ST_IDLE) || w_complete);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
      r_req_valid <= 1'b0;
      r_first     <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_addr      <= dmem_addr[XPR_LEN-1:2];
      r_wen       <= dmem_wen;
      r_wstrb     <= w_wstrb;
      r_first     <= 1'b1;
      r_req_valid <= !w_misaligned;
      r_state     <= w_misaligned ? ST_ERR : ST_ISSUE;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          // Store data arrives live in the first data-phase cycle; hold it for stalls.
          if (r_first) begin
            r_wdata <= dmem_wdata_delayed;
            r_first <= 1'b0;
          end
          if (bus_req_ready) begin
            r_state     <= ST_RESP;
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
          end
        end
        ST_RESP: begin
          if (w_complete) r_state <= ST_IDLE;
          else            r_cnt   <= r_cnt + 1'b1;
        end
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_wait     = (r_state == ST_ISSUE) || ((r_state == ST_RESP) && !w_complete);
  assign dmem_badmem_e = (r_state == ST_ERR) || w_timeout ||
                         ((r_state == ST_RESP) && bus_resp_valid && bus_resp_err);
  assign dmem_rdata    = ((r_state == ST_RESP) && !w_timeout) ? bus_resp_rdata : '0;

  assign bus_req_valid = r_req_valid;
  assign bus_req_addr  = {r_addr, 2'b00};
  assign bus_req_wen   = r_wen;
  assign bus_req_wstrb = r_wstrb;
  assign bus_req_wdata = r_first ? dmem_wdata_delayed : r_wdata;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Self-checking bench for vscale_dmem_bridge: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_vscale_dmem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dmem_en = 1'b0;
  logic        dmem_wen = 1'b0;
  logic [2:0]  dmem_size = 3'd0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata_delayed = '0;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_badmem_e;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid = 1'b0;
  logic [31:0] bus_resp_rdata = '0;
  logic        bus_resp_err = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: at most one outstanding access, either an error access, a request
  // waiting for ready, or a request waiting for its response.
  bit          m_busy = 0, m_err = 0, m_req = 0, m_first = 0, m_wen = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_strb = '0;
  int          m_waited = 0;

  logic        s_wait, s_bad, s_valid, s_wen;
  logic [31:0] s_rdata, s_addr, s_wdata;
  logic [3:0]  s_strb;

  always #5 clk = ~clk;

  vscale_dmem_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .dmem_en(dmem_en), .dmem_wen(dmem_wen),
    .dmem_size(dmem_size), .dmem_addr(dmem_addr), .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata), .dmem_badmem_e(dmem_badmem_e),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_wen(bus_req_wen), .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err)
  );

  function automatic bit exp_mis(input logic [1:0] sz, input logic [31:0] a);
    int n;
    n = 1 << sz;
    return (sz == 2'd3) || ((a % n) != 0);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a, input bit wen);
    int n, mask;
    if (!wen) return 4'h0;
    n = 1 << sz;
    mask = (1 << n) - 1;
    return 4'(mask << (a % 4));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic set_in(input logic en, input logic wen, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                        input logic rv, input logic [31:0] rd, input logic er);
    dmem_en = en; dmem_wen = wen; dmem_size = sz; dmem_addr = a;
    dmem_wdata_delayed = wd; bus_req_ready = rdy;
    bus_resp_valid = rv; bus_resp_rdata = rd; bus_resp_err = er;
  endtask

  // One clock: sample and check at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic        e_wait, e_bad, e_complete;
    logic [31:0] e_rdata;
    @(negedge clk);
    s_wait = dmem_wait; s_bad = dmem_badmem_e; s_rdata = dmem_rdata;
    s_valid = bus_req_valid; s_addr = bus_req_addr; s_wen = bus_req_wen;
    s_strb = bus_req_wstrb; s_wdata = bus_req_wdata;
    e_complete = 0; e_rdata = '0;
    if (!m_busy) begin
      e_wait = 0; e_bad = 0;
    end else if (m_err) begin
      e_wait = 0; e_bad = 1; e_complete = 1;
    end else if (m_req) begin
      e_wait = 1; e_bad = 0;
    end else if (bus_resp_valid) begin
      e_wait = 0; e_bad = bus_resp_err; e_rdata = bus_resp_rdata; e_complete = 1;
    end else if (m_waited == TO - 1) begin
      e_wait = 0; e_bad = 1; e_complete = 1;
    end else begin
      e_wait = 1; e_bad = 0;
    end
    chk1("req_valid", s_valid, m_busy && m_req);
    chk1("dmem_wait", s_wait, e_wait);
    chk1("badmem", s_bad, e_bad);
    if (e_complete) chk("rdata", s_rdata, e_rdata);
    if (m_busy && m_req) begin
      chk("req_addr", s_addr, m_addr);
      chk1("req_wen", s_wen, m_wen);
      chk("req_wstrb", {28'd0, s_strb}, {28'd0, m_strb});
      if (m_wen) chk("req_wdata", s_wdata, m_first ? dmem_wdata_delayed : m_wdata);
    end
    @(posedge clk);
    if (!m_busy || e_complete) begin
      if (dmem_en) begin
        m_busy = 1; m_err = exp_mis(dmem_size[1:0], dmem_addr); m_req = !m_err;
        m_first = 1; m_addr = dmem_addr & ~32'd3; m_wen = dmem_wen;
        m_strb = exp_strb(dmem_size[1:0], dmem_addr, dmem_wen); m_waited = 0;
      end else begin
        m_busy = 0;
      end
    end else if (m_req) begin
      if (m_first) begin
        m_wdata = dmem_wdata_delayed; m_first = 0;
      end
      if (bus_req_ready) m_req = 0;
    end else begin
      m_waited++;
    end
    #1;
  endtask

  initial begin
    #1;
    chk1("rst_wait", dmem_wait, 1'b0);
    chk1("rst_valid", bus_req_valid, 1'b0);
    chk1("rst_bad", dmem_badmem_e, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    // LW 0x100: ready at N+1, response at N+2
    set_in(1, 0, 3'd2, 32'h100, 0, 0, 0, 0, 0); step();
    chk1("lw_n_wait", s_wait, 1'b0);
    set_in(0, 0, 3'd2, 0, 0, 1, 0, 0, 0); step();
    chk1("lw_n1_wait", s_wait, 1'b1);
    chk1("lw_n1_valid", s_valid, 1'b1);
    chk("lw_addr", s_addr, 32'h100);
    chk("lw_strb", {28'd0, s_strb}, 32'h0);
    set_in(0, 0, 3'd2, 0, 0, 0, 1, 32'hDEADBEEF, 0); step();
    chk1("lw_n2_wait", s_wait, 1'b0);
    chk("lw_rdata", s_rdata, 32'hDEADBEEF);
    chk1("lw_bad", s_bad, 1'b0);

    // SB 0x203 with ready held low for three cycles
    set_in(1, 1, 3'd0, 32'h203, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1, 3'd0, 0, (k == 0) ? 32'h77777777 : $urandom, (k == 3), 0, 0, 0); step();
      chk("sb_addr", s_addr, 32'h200);
      chk("sb_strb", {28'd0, s_strb}, 32'h8);
      chk("sb_wdata", s_wdata, 32'h77777777);
      chk1("sb_wait", s_wait, 1'b1);
    end
    set_in(0, 0, 3'd0, 0, 0, 0, 0, 0, 0); step();
    chk1("sb_resp_wait", s_wait, 1'b1);
    set_in(0, 0, 3'd0, 0, 0, 0, 1, 0, 0); step();
    chk1("sb_done_wait", s_wait, 1'b0);

    // Misaligned LH and illegal size both take the one-cycle error path
    for (int k = 0; k < 2; k++) begin
      set_in(1, 0, (k == 0) ? 3'd1 : 3'd3, (k == 0) ? 32'h101 : 32'h0, 0, 1, 0, 0, 0); step();
      set_in(0, 0, 3'd0, 0, 0, 1, 0, 0, 0); step();
      chk1("err_valid", s_valid, 1'b0);
      chk1("err_wait", s_wait, 1'b0);
      chk1("err_bad", s_bad, 1'b1);
    end

    // Back-to-back SW 0x10 then LW 0x14 without an idle bubble
    set_in(1, 1, 3'd2, 32'h10, 0, 0, 0, 0, 0); step();
    set_in(0, 1, 3'd2, 0, 32'h12345678, 1, 0, 0, 0); step();
    set_in(1, 0, 3'd2, 32'h14, 0, 0, 1, 0, 0); step();
    chk1("b2b_k_wait", s_wait, 1'b0);
    set_in(0, 0, 3'd2, 0, 0, 0, 0, 0, 0); step();
    chk1("b2b_valid", s_valid, 1'b1);
    chk("b2b_addr", s_addr, 32'h14);
    set_in(0, 0, 3'd2, 0, 0, 1, 0, 0, 0); step();
    set_in(0, 0, 3'd2, 0, 0, 0, 1, 32'h5, 0); step();

    // Timeout after four silent response cycles; late response dropped
    set_in(1, 0, 3'd2, 32'h40, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 3'd2, 0, 0, 1, 0, 0, 0); step();
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 0, 3'd2, 0, 0, 0, 0, 32'hFFFFFFFF, 0); step();
      chk1("to_wait", s_wait, (k < 4) ? 1'b1 : 1'b0);
      chk1("to_bad", s_bad, (k < 4) ? 1'b0 : 1'b1);
    end
    chk("to_rdata", s_rdata, 32'h0);
    set_in(0, 0, 3'd2, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 3'd2, 0, 0, 0, 1, 32'hABCD, 1); step();
    chk1("late_bad", s_bad, 1'b0);
    chk1("late_wait", s_wait, 1'b0);

    // Asynchronous reset while waiting for a response
    set_in(1, 0, 3'd2, 32'h80, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 3'd2, 0, 0, 1, 0, 0, 0); step();
    set_in(0, 0, 3'd2, 0, 0, 0, 0, 0, 0);
    #2;
    chk1("pre_rst_wait", dmem_wait, 1'b1);
    reset = 1'b1;
    #1;
    chk1("arst_valid", bus_req_valid, 1'b0);
    chk1("arst_wait", dmem_wait, 1'b0);
    m_busy = 0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    set_in(0, 0, 3'd2, 0, 0, 0, 1, 32'h99, 1); step();
    chk1("post_rst_bad", s_bad, 1'b0);
    chk1("post_rst_wait", s_wait, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = $urandom & 32'hFFF;
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3,
             a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
             $urandom, ($urandom_range(0, 4) == 0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
